// File: rtl/bitcoin_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitcoin_pkg: constants and types shared by the memory front-end, the hash   |
// | core and the bench.                                       Revision: 1.0     |
// +----------------------------------------------------------------------------+
package bitcoin_pkg;

  localparam int unsigned NUM_NONCES = 16;
  localparam int unsigned HDR_WORDS  = 19;
  localparam int unsigned MSG_BITS   = 640;
  localparam logic [31:0] PAD_WORD   = 32'h8000_0000;
  localparam int unsigned CNT_W      = $clog2(NUM_NONCES + 1);

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bitcoin_blk_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitcoin_blk_mux: combinational selector for block-1/block-2 message words.  |
// |                                                           Revision: 1.0     |
// +----------------------------------------------------------------------------+
module bitcoin_blk_mux
  import bitcoin_pkg::*;
(
  input  word_t       i_hdr [HDR_WORDS],
  input  logic        i_hdr_valid,
  input  logic        i_blk_sel,
  input  logic [3:0]  i_word_idx,
  input  word_t       i_nonce,
  output word_t       o_word_out
);

  always_comb begin
    o_word_out = '0;
    if (i_hdr_valid) begin
      if (!i_blk_sel) begin
        o_word_out = i_hdr[{1'b0, i_word_idx}];
      end else begin
        // Block 2: header tail, nonce, then SHA-256 padding and length.
        case (i_word_idx)
          4'd0, 4'd1, 4'd2: o_word_out = i_hdr[5'd16 + {1'b0, i_word_idx}];
          4'd3:             o_word_out = i_nonce;
          4'd4:             o_word_out = PAD_WORD;
          4'd15:            o_word_out = 32'(MSG_BITS);
          default:          o_word_out = '0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bitcoin_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bitcoin_mem_if: header fetch, message word port and H0 result writeback on  |
// | the shared single-port memory.                            Revision: 1.0     |
// +----------------------------------------------------------------------------+
module bitcoin_mem_if
  import bitcoin_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        hdr_valid,
  input  logic        blk_sel,
  input  logic [3:0]  word_idx,
  input  logic [31:0] nonce,
  output logic [31:0] word_out,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [7:0]  res_idx,
  input  logic [31:0] res_data
);

  localparam logic [4:0] c_FETCH_END = 5'(HDR_WORDS);
  localparam logic [4:0] c_ADDR_LAST = 5'(HDR_WORDS - 1);

  state_t           r_state;
  state_t           w_state_next;
  word_t            r_hdr [HDR_WORDS];
  logic [4:0]       r_fcnt;
  logic [15:0]      r_out_addr;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_start;
  logic             w_accept;
  logic             w_in_range;
  logic             w_last;

  assign mem_clk    = clk;
  assign res_ready  = (r_state == ST_READY);
  assign w_start    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_accept   = res_ready && res_valid;
  assign w_in_range = 32'(res_idx) < NUM_NONCES;
  assign w_cnt_inc  = r_wr_cnt + 1'b1;
  assign w_last     = w_accept && w_in_range && (w_cnt_inc == CNT_W'(NUM_NONCES));

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_FETCH;
      ST_FETCH: if (r_fcnt == c_FETCH_END) w_state_next = ST_READY;
      ST_READY: if (w_last) w_state_next = ST_DONE;
      ST_DONE:  if (start) w_state_next = ST_FETCH;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done           <= 1'b0;
      hdr_valid      <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      r_fcnt         <= '0;
      r_out_addr     <= '0;
      r_wr_cnt       <= '0;
      for (int i = 0; i < HDR_WORDS; i++) r_hdr[i] <= '0;
    end else begin
      mem_we <= 1'b0;
      if (w_start) begin
        r_out_addr <= output_addr;
        mem_addr   <= message_addr;
        r_fcnt     <= '0;
        r_wr_cnt   <= '0;
        done       <= 1'b0;
        hdr_valid  <= 1'b0;
      end else begin
        case (r_state)
          ST_FETCH: begin
            // Read data lags the issued address by two edges.
            if (r_fcnt != 5'd0) r_hdr[r_fcnt - 5'd1] <= mem_read_data;
            if (r_fcnt < c_ADDR_LAST) mem_addr <= mem_addr + 16'd1;
            if (r_fcnt == c_FETCH_END) hdr_valid <= 1'b1;
            else                       r_fcnt    <= r_fcnt + 5'd1;
          end
          ST_READY: begin
            if (w_accept && w_in_range) begin
              mem_we         <= 1'b1;
              mem_addr       <= r_out_addr + {8'd0, res_idx};
              mem_write_data <= res_data;
              r_wr_cnt       <= w_cnt_inc;
            end
          end
          ST_DONE:  done <= 1'b1;
          default:  ;
        endcase
      end
    end
  end

  bitcoin_blk_mux u_blk_mux (
    .i_hdr       (r_hdr),
    .i_hdr_valid (hdr_valid),
    .i_blk_sel   (blk_sel),
    .i_word_idx  (word_idx),
    .i_nonce     (nonce),
    .o_word_out  (word_out)
  );

endmodule
`default_nettype wire

// File: doc/bitcoin_mem_if.md
Name: bitcoin_mem_if

Overview:
Memory front-end for the bitcoin hash co-processor, sharing its single-port memory interface.
- On start, fetches the 19-word block header from memory at message_addr into a register file.
- Serves the 16-word message blocks (block 1 raw; block 2 padded, with nonce inserted) to the hash core through a combinational word port.
- Collects per-nonce H0 results from the core and writes them to output_addr+nonce_idx, then raises done.

Parameters:
- NUM_NONCES, 16, number of H0 results expected before done.
- HDR_WORDS, 19, header words fetched. Fixed by the protocol; not to be overridden.
- MSG_BITS, 640, length field placed in block 2 word 15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset (see Behaviour).
- start  in  1  level, sampled only in IDLE or DONE.
- message_addr  in  16  header base address; latched at start.
- output_addr  in  16  result base address; latched at start.
- done  out  1  all NUM_NONCES results written.
- mem_clk  out  1  equals clk (assign).
- mem_we  out  1  registered; 1 = write.
- mem_addr  out  16  registered memory address.
- mem_write_data  out  32  registered write data.
- mem_read_data  in  32  read data for the address sampled at the previous mem_clk edge.
- hdr_valid  out  1  header register file complete.
- blk_sel  in  1  0 = block 1, 1 = block 2.
- word_idx  in  4  word index 0..15.
- nonce  in  32  nonce value for block 2 word 3.
- word_out  out  32  combinational message word.
- res_valid  in  1  result offered.
- res_ready  out  1  result accepted when res_valid & res_ready.
- res_idx  in  8  nonce index of the result.
- res_data  in  32  H0 value.

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk.
- Reset values: state IDLE; done, hdr_valid, res_ready, mem_we = 0; mem_addr, mem_write_data = 0; header regs and write counter = 0.
- Reset asserted mid-operation aborts at the next edge. No further memory writes are issued.
- FSM states: IDLE, FETCH, READY, DONE.
- IDLE -> FETCH when start=1 at edge E0:
  - latch both base addresses;
  - mem_addr <= message_addr; mem_we <= 0.
- FETCH issue:
  - mem_addr increments once per edge through message_addr+18, then holds.
  - Addresses wrap modulo 2^16.
- FETCH capture:
  - word k is captured from mem_read_data at edge E(k+2) into hdr[k].
  - hdr[18] is captured at E20. At E20: state -> READY, hdr_valid <= 1.
- Fetch latency: 20 cycles from start sample to hdr_valid.
- start is ignored in FETCH and READY.
- Word port (combinational from registers):
  - blk_sel=0: word_out = hdr[word_idx].
  - blk_sel=1: idx 0..2 -> hdr[16..18]; idx 3 -> nonce; idx 4 -> 32'h80000000; idx 5..14 -> 0; idx 15 -> MSG_BITS.
  - Valid only while hdr_valid=1. Otherwise word_out = 0.
- READY writeback:
  - res_ready = 1 (combinational, state==READY).
  - On an accept edge: mem_we <= 1, mem_addr <= output_addr+res_idx, mem_write_data <= res_data, wr_cnt++.
  - Edges with no accept: mem_we <= 0.
  - Back-to-back accepts give one write per cycle.
  - res_idx >= NUM_NONCES: accepted but dropped (mem_we stays 0, wr_cnt unchanged).
  - A duplicate res_idx is rewritten and counted.
- READY -> DONE on the accept edge that makes wr_cnt == NUM_NONCES.
  - The last write is driven in the cycle after that edge (the first DONE cycle).
  - done <= 1 one edge later, so memory has captured the data before done is seen.
- DONE:
  - res_ready = 0; mem_we <= 0; done held.
  - hdr_valid stays 1.
  - start=1 -> clear done, hdr_valid, wr_cnt; enter FETCH (same as from IDLE).
- wr_cnt width: clog2(NUM_NONCES+1).

Decomposition:
- Package bitcoin_pkg holds: NUM_NONCES, HDR_WORDS, MSG_BITS, PAD_WORD (32'h80000000), the state enum, and the 32-bit word typedef. These are shared with the hash core and the bench.
- One natural sub-module: bitcoin_blk_mux, the combinational block-word selector (hdr file + nonce -> word_out).
- The FSM and memory sequencing stay in the top module.

Test Plan:
1. Fetch. Seed 32'h01234567 at mem[0..18], each word rotl1 of the previous; message_addr=0; start pulse.
   -> hdr_valid rises 20 cycles after the start sample.
   -> blk_sel=0, idx=1 gives 32'h02468ace; blk_sel=0, idx=15 gives the rotl15 word.
   -> mem_we stays 0 throughout.
2. Block 2 word port. blk_sel=1 with nonce=5:
   -> idx 0 = hdr[16]; idx 3 = 5; idx 4 = 32'h80000000; idx 9 = 0; idx 15 = 640.
3. Writeback. output_addr=32; feed res_idx 0..15 with data 32'hA000_0000+idx, back-to-back.
   -> mem[32..47] hold those values.
   -> done=1 two cycles after the 16th accept; res_ready=0 in DONE.
4. Out-of-range index. res_idx=20 accepted in READY.
   -> no memory write; done is not reached until 16 valid indices are accepted.
5. Reset during FETCH. reset_n=0 at cycle 8 of fetch.
   -> next edge: state IDLE, hdr_valid=0, mem_we=0.
   -> a new start refetches correctly.
6. Start handling. start held through FETCH: no restart, hdr_valid timing unchanged. start in DONE: done clears next edge and a new fetch begins from the newly latched message_addr.
